// File: rtl/axi3_hp_burst_reader.sv
// axi3_hp_burst_reader: AXI3 HP-port read master issuing fixed-length INCR bursts
// with up to MAX_OUTSTANDING bursts in flight and a combinational R pass-through.
module axi3_hp_burst_reader #(
    parameter int DATA_WIDTH      = 32,
    parameter int BURST_LEN       = 8,
    parameter int MAX_OUTSTANDING = 2,
    parameter int ADDR_WIDTH      = 32
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [ADDR_WIDTH-1:0] DMA_RD_ADDR,
    input  logic                  DMA_START,
    output logic                  DMA_READY,
    output logic                  DMA_BUSY,
    output logic [DATA_WIDTH-1:0] DMA_RD_DATA,
    output logic                  DMA_RD_DATA_VALID,
    output logic                  DMA_RD_DATA_LAST,
    input  logic                  DMA_RD_DATA_READY,
    output logic                  DMA_ERROR,
    input  logic                  m00_axi_arready,
    output logic                  m00_axi_arvalid,
    output logic [ADDR_WIDTH-1:0] m00_axi_araddr,
    output logic [3:0]            m00_axi_arlen,
    output logic [2:0]            m00_axi_arsize,
    output logic [1:0]            m00_axi_arburst,
    input  logic                  m00_axi_rvalid,
    input  logic                  m00_axi_rlast,
    input  logic [1:0]            m00_axi_rresp,
    input  logic [DATA_WIDTH-1:0] m00_axi_rdata,
    output logic                  m00_axi_rready
);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int AL = $clog2(BURST_LEN * DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = {ADDR_WIDTH{1'b1}} << AL;
    localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);
    localparam logic [3:0] LAST_BEAT = 4'(BURST_LEN - 1);

    typedef enum logic {IDLE, ADDR} state_t;

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] araddr, araddr_next;
    logic [OW-1:0]         outstanding, outstanding_next;
    logic [3:0]            beat, beat_next;
    logic                  error, error_next;
    logic                  accept, ar_hs, r_hs, r_done, beat_bad;

    always_comb begin
        DMA_READY        = !RESET && state == IDLE && outstanding < MAX_OUT;
        accept           = DMA_READY && DMA_START;
        ar_hs            = state == ADDR && m00_axi_arready;
        state_next       = accept ? ADDR : ar_hs ? IDLE : state;
        araddr_next      = accept ? (DMA_RD_ADDR & ADDR_MASK) : araddr;
        r_hs             = m00_axi_rvalid && DMA_RD_DATA_READY;
        r_done           = r_hs && m00_axi_rlast;
        beat_bad         = m00_axi_rresp != 2'b00 || m00_axi_rlast != (beat == LAST_BEAT)
                           || outstanding == '0;
        error_next       = error || (r_hs && beat_bad);
        beat_next        = r_done ? 4'd0 : r_hs ? beat + 4'd1 : beat;
        // an unsolicited rlast must not wrap the counter below zero
        outstanding_next = outstanding + OW'(ar_hs) - OW'(r_done && outstanding != '0);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= IDLE;
            araddr      <= '0;
            outstanding <= '0;
            beat        <= '0;
            error       <= 1'b0;
        end else begin
            state       <= state_next;
            araddr      <= araddr_next;
            outstanding <= outstanding_next;
            beat        <= beat_next;
            error       <= error_next;
        end
    end

    assign m00_axi_arvalid   = state == ADDR;
    assign m00_axi_araddr    = araddr;
    assign m00_axi_arlen     = LAST_BEAT;
    assign m00_axi_arsize    = 3'($clog2(DATA_WIDTH / 8));
    assign m00_axi_arburst   = 2'b01;
    assign m00_axi_rready    = DMA_RD_DATA_READY;
    assign DMA_RD_DATA       = m00_axi_rdata;
    assign DMA_RD_DATA_VALID = m00_axi_rvalid;
    assign DMA_RD_DATA_LAST  = m00_axi_rlast;
    assign DMA_BUSY          = m00_axi_arvalid || outstanding != '0;
    assign DMA_ERROR         = error;
endmodule

// File: tb/tb_axi3_hp_burst_reader.sv
// tb_axi3_hp_burst_reader: random AXI slave stimulus, behavioural model and
// queue scoreboard for axi3_hp_burst_reader.
module tb_axi3_hp_burst_reader;
    localparam int DW    = 32;
    localparam int BL    = 8;
    localparam int MO    = 2;
    localparam int AW    = 32;
    localparam int ALIGN = BL * DW / 8;

    logic          CLK = 1'b0, RESET = 1'b1;
    logic [AW-1:0] DMA_RD_ADDR = '0;
    logic          DMA_START = 1'b0, DMA_READY, DMA_BUSY;
    logic [DW-1:0] DMA_RD_DATA;
    logic          DMA_RD_DATA_VALID, DMA_RD_DATA_LAST, DMA_RD_DATA_READY = 1'b0, DMA_ERROR;
    logic          m00_axi_arready = 1'b0, m00_axi_arvalid;
    logic [AW-1:0] m00_axi_araddr;
    logic [3:0]    m00_axi_arlen;
    logic [2:0]    m00_axi_arsize;
    logic [1:0]    m00_axi_arburst;
    logic          m00_axi_rvalid = 1'b0, m00_axi_rlast = 1'b0, m00_axi_rready;
    logic [1:0]    m00_axi_rresp = 2'b00;
    logic [DW-1:0] m00_axi_rdata = '0;

    axi3_hp_burst_reader #(.DATA_WIDTH(DW), .BURST_LEN(BL), .MAX_OUTSTANDING(MO), .ADDR_WIDTH(AW)) dut (
        .CLK(CLK), .RESET(RESET), .DMA_RD_ADDR(DMA_RD_ADDR), .DMA_START(DMA_START),
        .DMA_READY(DMA_READY), .DMA_BUSY(DMA_BUSY), .DMA_RD_DATA(DMA_RD_DATA),
        .DMA_RD_DATA_VALID(DMA_RD_DATA_VALID), .DMA_RD_DATA_LAST(DMA_RD_DATA_LAST),
        .DMA_RD_DATA_READY(DMA_RD_DATA_READY), .DMA_ERROR(DMA_ERROR),
        .m00_axi_arready(m00_axi_arready), .m00_axi_arvalid(m00_axi_arvalid),
        .m00_axi_araddr(m00_axi_araddr), .m00_axi_arlen(m00_axi_arlen),
        .m00_axi_arsize(m00_axi_arsize), .m00_axi_arburst(m00_axi_arburst),
        .m00_axi_rvalid(m00_axi_rvalid), .m00_axi_rlast(m00_axi_rlast),
        .m00_axi_rresp(m00_axi_rresp), .m00_axi_rdata(m00_axi_rdata),
        .m00_axi_rready(m00_axi_rready)
    );

    always #5 CLK = ~CLK;

    int checks = 0, errors = 0;
    int ar_cnt = 0, r_cnt = 0;
    logic [AW-1:0] last_araddr = '0;
    logic [3:0]    last_arlen = '0;
    logic [2:0]    last_arsize = '0;
    logic [1:0]    last_arburst = '0;

    // reference model state
    int  m_out = 0, m_beat = 0;
    bit  m_pending = 0, m_err = 0;
    logic [AW-1:0] exp_ar[$];
    logic [DW:0]   exp_r[$];

    // slave / stimulus state
    logic [AW-1:0] bursts[$];
    logic [AW-1:0] last_ar_addr = '0, fixed_addr = '0;
    int  beat_i = 0, inj_resp = -1, early_last = -1;
    int  ar_pct = 100, rv_pct = 100, rdy_pct = 100, start_pct = 0;
    bit  r_en = 1, rdy_toggle = 0, use_fixed = 0, presenting = 0;
    bit  last_ar_hs = 0, last_r_hs = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Model: outstanding bursts, AR pending and error flag derived from the handshake rules.
    always @(posedge CLK) begin
        if (RESET) begin
            m_out <= 0; m_pending <= 0; m_err <= 0; m_beat <= 0;
            exp_ar.delete();
        end else begin
            if (m00_axi_rvalid && DMA_RD_DATA_READY) begin
                if (m00_axi_rresp != 2'b00 || m_out == 0 || m00_axi_rlast != (m_beat == BL - 1))
                    m_err <= 1;
                m_beat <= m00_axi_rlast ? 0 : (m_beat + 1) % 16;
            end
            m_out <= m_out + ((m_pending && m00_axi_arready) ? 1 : 0)
                     - ((m00_axi_rvalid && DMA_RD_DATA_READY && m00_axi_rlast && m_out > 0) ? 1 : 0);
            if (DMA_START && !m_pending && m_out < MO) begin
                m_pending <= 1;
                exp_ar.push_back((DMA_RD_ADDR / ALIGN) * ALIGN);
            end else if (m_pending && m00_axi_arready)
                m_pending <= 0;
        end
    end

    // Monitor: compares DUT outputs with the model and pops scoreboard queues on handshakes.
    initial forever begin
        logic [AW-1:0] ea;
        logic [DW:0]   er;
        @(negedge CLK); #1;
        chk("dma_ready", DMA_READY, !RESET && !m_pending && m_out < MO);
        chk("arvalid", m00_axi_arvalid, m_pending);
        chk("dma_busy", DMA_BUSY, m_pending || m_out != 0);
        chk("dma_error", DMA_ERROR, m_err);
        chk("rready", m00_axi_rready, DMA_RD_DATA_READY);
        chk("rvalid_pass", DMA_RD_DATA_VALID, m00_axi_rvalid);
        if (m00_axi_arvalid && m00_axi_arready) begin
            ar_cnt++;
            last_araddr = m00_axi_araddr; last_arlen = m00_axi_arlen;
            last_arsize = m00_axi_arsize; last_arburst = m00_axi_arburst;
            chk("ar_queue_nonempty", exp_ar.size() > 0, 1);
            if (exp_ar.size() > 0) begin
                ea = exp_ar.pop_front();
                chk("araddr", m00_axi_araddr, ea);
            end
            chk("arlen", m00_axi_arlen, BL - 1);
            chk("arsize", m00_axi_arsize, $clog2(DW / 8));
            chk("arburst", m00_axi_arburst, 2'b01);
        end
        if (DMA_RD_DATA_VALID && DMA_RD_DATA_READY) begin
            r_cnt++;
            chk("r_queue_nonempty", exp_r.size() > 0, 1);
            if (exp_r.size() > 0) begin
                er = exp_r.pop_front();
                chk("rbeat", {DMA_RD_DATA_LAST, DMA_RD_DATA}, er);
            end
        end
    end

    // One cycle of AXI-slave and DMA-side stimulus, driven on the falling edge.
    task automatic step();
        @(negedge CLK);
        if (last_ar_hs) bursts.push_back(last_ar_addr);
        if (last_r_hs) begin
            presenting = 0;
            if (m00_axi_rlast) begin
                void'(bursts.pop_front());
                beat_i = 0;
            end else beat_i++;
        end
        m00_axi_arready   = $urandom_range(99) < ar_pct;
        DMA_RD_DATA_READY = rdy_toggle ? !DMA_RD_DATA_READY : ($urandom_range(99) < rdy_pct);
        DMA_START         = $urandom_range(99) < start_pct;
        DMA_RD_ADDR       = use_fixed ? fixed_addr : AW'($urandom);
        if (!presenting && r_en && bursts.size() > 0 && $urandom_range(99) < rv_pct) begin
            presenting    = 1;
            m00_axi_rdata = DW'({$urandom, $urandom});
            m00_axi_rlast = (beat_i == BL - 1) || (beat_i == early_last);
            m00_axi_rresp = (beat_i == inj_resp) ? 2'b10 : 2'b00;
            if (beat_i == early_last) early_last = -1;
            if (beat_i == inj_resp) inj_resp = -1;
            exp_r.push_back({m00_axi_rlast, m00_axi_rdata});
        end
        m00_axi_rvalid = presenting;
        last_ar_hs   = m00_axi_arvalid && m00_axi_arready;
        last_ar_addr = m00_axi_araddr;
        last_r_hs    = presenting && DMA_RD_DATA_READY;
    endtask

    task automatic issue_one();
        int n = 0;
        start_pct = 100;
        step();
        while (!m_pending && n < 50) begin
            step();
            n++;
        end
        start_pct = 0;
        chk("issue_accepted", m_pending, 1);
    endtask

    task automatic drain();
        int n = 0;
        start_pct = 0;
        r_en = 1;
        while ((m_out != 0 || m_pending || bursts.size() != 0 || presenting) && n < 3000) begin
            step();
            n++;
        end
        chk("drain_done", n < 3000, 1);
    endtask

    task automatic apply_reset();
        @(negedge CLK);
        RESET = 1; DMA_START = 0; m00_axi_arready = 0; m00_axi_rvalid = 0;
        presenting = 0; bursts.delete(); exp_r.delete();
        last_ar_hs = 0; last_r_hs = 0; beat_i = 0;
        @(negedge CLK); #2;
        chk("rst_arvalid", m00_axi_arvalid, 0);
        chk("rst_busy", DMA_BUSY, 0);
        chk("rst_error", DMA_ERROR, 0);
        chk("rst_ready_low", DMA_READY, 0);
        RESET = 0;
        #1;
        chk("post_rst_ready", DMA_READY, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int r0, a0;
        repeat (3) @(negedge CLK);
        #1;
        chk("reset_ready", DMA_READY, 0);
        chk("reset_arvalid", m00_axi_arvalid, 0);
        RESET = 0;
        #1;
        chk("first_ready", DMA_READY, 1);

        // directed burst: arready after 3 cycles, misaligned start address
        use_fixed = 1; fixed_addr = 32'h1000_0004; ar_pct = 0; r0 = r_cnt;
        issue_one();
        repeat (3) step();
        ar_pct = 100;
        drain();
        use_fixed = 0;
        chk("t1_araddr", last_araddr, 32'h1000_0000);
        chk("t1_arlen", last_arlen, 7);
        chk("t1_arsize", last_arsize, 2);
        chk("t1_arburst", last_arburst, 1);
        chk("t1_beats", r_cnt - r0, 8);
        chk("t1_error", DMA_ERROR, 0);
        chk("t1_busy", DMA_BUSY, 0);

        // outstanding limit with no R traffic
        a0 = ar_cnt; r_en = 0; start_pct = 100;
        repeat (12) step();
        chk("t2_two_ar", ar_cnt - a0, 2);
        chk("t2_ready_low", DMA_READY, 0);
        r_en = 1;
        for (int n = 0; n < 200 && ar_cnt - a0 < 3; n++) step();
        start_pct = 0;
        chk("t2_third_ar", ar_cnt - a0, 3);
        drain();

        // downstream ready toggling every cycle
        rdy_toggle = 1; r0 = r_cnt;
        issue_one();
        drain();
        rdy_toggle = 0;
        chk("t3_beats", r_cnt - r0, 8);

        // randomized traffic
        ar_pct = 60; rv_pct = 70; rdy_pct = 70; start_pct = 30;
        repeat (600) step();
        drain();
        chk("rand_no_error", DMA_ERROR, 0);
        ar_pct = 100; rv_pct = 100; rdy_pct = 100;

        // RRESP error on beat 3, sticky through a clean burst
        inj_resp = 3;
        issue_one();
        drain();
        chk("t4_error", DMA_ERROR, 1);
        issue_one();
        drain();
        chk("t4_sticky", DMA_ERROR, 1);

        // reset with a burst outstanding and AR pending
        r_en = 0;
        issue_one();
        repeat (3) step();
        ar_pct = 0;
        issue_one();
        step();
        chk("t5_pre_arvalid", m00_axi_arvalid, 1);
        chk("t5_pre_busy", DMA_BUSY, 1);
        apply_reset();
        ar_pct = 100; r_en = 1;

        // early rlast on beat 5, then a clean burst
        early_last = 4;
        issue_one();
        drain();
        chk("t6_error", DMA_ERROR, 1);
        chk("t6_busy", DMA_BUSY, 0);
        r0 = r_cnt;
        issue_one();
        drain();
        chk("t6_next_beats", r_cnt - r0, 8);
        chk("t6_busy_after", DMA_BUSY, 0);

        step();
        chk("end_exp_ar_empty", exp_ar.size(), 0);
        chk("end_exp_r_empty", exp_r.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
